// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the mac_seq dot-product sequencer.
// States, pipeline depths and the per-element tag that rides alongside the MAC.
// Optional feature macro used by this slice: MAC_SEQ_BIAS_EN.
package mac_seq_pkg;

  localparam int RD_LAT    = 1;        // rd_en to a_rdata/b_rdata
  localparam int MAC_LAT   = 4;        // ain to pout
  localparam int TAG_DEPTH = MAC_LAT;  // tag reaches the last stage when cin is chosen

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic valid;
    logic first;
  } tag_t;

endpackage

// File: rtl/mac_seq_if.sv
// Control/status and operand-memory bundle for mac_seq.
// master = register block + memories, slave = sequencer.
// bias only exists when MAC_SEQ_BIAS_EN is defined.
interface mac_seq_if #(
  parameter int AW  = 27,
  parameter int BW  = 18,
  parameter int PW  = 48,
  parameter int ADW = 10,
  parameter int LW  = 11
);
  logic                  start;
  logic [LW-1:0]         len;
  logic [ADW-1:0]        a_base;
  logic [ADW-1:0]        b_base;
  logic                  busy;
  logic                  done;
  logic signed [PW-1:0]  result;
  logic                  rd_en;
  logic [ADW-1:0]        a_addr;
  logic [ADW-1:0]        b_addr;
  logic signed [AW-1:0]  a_rdata;
  logic signed [BW-1:0]  b_rdata;
`ifdef MAC_SEQ_BIAS_EN
  logic signed [PW-1:0]  bias;
`endif

  modport master (
    output start, len, a_base, b_base, a_rdata, b_rdata,
`ifdef MAC_SEQ_BIAS_EN
    output bias,
`endif
    input  busy, done, result, rd_en, a_addr, b_addr
  );

  modport slave (
    input  start, len, a_base, b_base, a_rdata, b_rdata,
`ifdef MAC_SEQ_BIAS_EN
    input  bias,
`endif
    output busy, done, result, rd_en, a_addr, b_addr
  );
endinterface

// File: rtl/mac_seq_mac.sv
// DSP-style multiply-accumulate: pout = ain_d2 * bin_d1 + cin (registered).
// Latency: ain to pout 4 cycles, bin to pout 3 cycles, cin to pout 1 cycle.
// No backpressure; free-running pipeline with no reset (contents qualified externally).
module mac #(
  parameter int AW = 27,
  parameter int BW = 18,
  parameter int PW = 48
) (
  input  logic                 clk,
  input  logic signed [AW-1:0] ain,
  input  logic signed [BW-1:0] bin,
  input  logic signed [PW-1:0] cin,
  output logic signed [PW-1:0] pout,
  output logic signed [AW-1:0] acout
);
  localparam int MW = AW + BW;

  logic signed [AW-1:0] a1_q, a1_d, a2_q, a2_d;
  logic signed [BW-1:0] b1_q, b1_d;
  logic signed [MW-1:0] m_q, m_d;
  logic signed [PW-1:0] p_q, p_d;

  // Operand skew registers, full-width signed product, post-adder
  always_comb begin
    a1_d = ain;
    a2_d = a1_q;
    b1_d = bin;
    m_d  = MW'(a2_q) * MW'(b1_q);
    p_d  = {{(PW-MW){m_q[MW-1]}}, m_q} + cin;
  end

  // Pipeline registers
  always_ff @(posedge clk) begin
    a1_q <= a1_d;
    a2_q <= a2_d;
    b1_q <= b1_d;
    m_q  <= m_d;
    p_q  <= p_d;
  end

  assign pout  = p_q;
  assign acout = a2_q;
endmodule

// File: rtl/mac_seq.sv
// Dot-product sequencer: streams N operand pairs from two memories through one mac.
// Latency: start accept to done pulse N+6 cycles (N>=1), 1 cycle for N=0.
// No backpressure; start is only accepted in IDLE. MAC_SEQ_BIAS_EN seeds the sum with bias.
module mac_seq
  import mac_seq_pkg::*;
#(
  parameter int AW  = 27,
  parameter int BW  = 18,
  parameter int PW  = 48,
  parameter int ADW = 10,
  parameter int LW  = 11
) (
  input logic     clk,
  input logic     rst_n,
  mac_seq_if.slave bus
);
  state_t               state_q, state_d;
  logic [LW-1:0]        cnt_q, cnt_d;
  logic [ADW-1:0]       a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic                 first_q, first_d;
  logic signed [PW-1:0] result_q, result_d;
  logic signed [BW-1:0] b_skew_q, b_skew_d;
  tag_t                 tag_q [TAG_DEPTH];
  tag_t                 tag_d [TAG_DEPTH];
  logic signed [PW-1:0] pout, cin, init_acc;
  logic signed [AW-1:0] acout_unused;
  logic                 issue, pipe_empty;

`ifdef MAC_SEQ_BIAS_EN
  assign init_acc = bus.bias;
`else
  assign init_acc = '0;
`endif

  // Pipeline is drained once no tag is in flight; pout then holds the final sum
  always_comb begin
    pipe_empty = 1'b1;
    for (int i = 0; i < TAG_DEPTH; i++) begin
      if (tag_q[i].valid) pipe_empty = 1'b0;
    end
  end

  // Sequencer next-state, address/count updates and result capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    first_d  = first_q;
    result_d = result_q;
    issue    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_addr_d = bus.a_base;
          b_addr_d = bus.b_base;
          cnt_d    = bus.len;
          first_d  = 1'b1;
          if (bus.len == '0) begin
            result_d = init_acc;
            state_d  = DONE;
          end else begin
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        issue    = 1'b1;
        a_addr_d = a_addr_q + ADW'(1);
        b_addr_d = b_addr_q + ADW'(1);
        cnt_d    = cnt_q - LW'(1);
        first_d  = 1'b0;
        if (cnt_q == LW'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pipe_empty) begin
          result_d = pout;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tag shift register tracks each issued element; B gets one skew stage
  always_comb begin
    tag_d[0].valid = issue;
    tag_d[0].first = first_q;
    for (int i = 1; i < TAG_DEPTH; i++) tag_d[i] = tag_q[i-1];
    b_skew_d = bus.b_rdata;
  end

  // First product of a job starts from the seed, later ones chain on pout
  always_comb begin
    cin = pout;
    if (tag_q[TAG_DEPTH-1].valid && tag_q[TAG_DEPTH-1].first) cin = init_acc;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      first_q  <= 1'b0;
      result_q <= '0;
      b_skew_q <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      first_q  <= first_d;
      result_q <= result_d;
      b_skew_q <= b_skew_d;
      for (int i = 0; i < TAG_DEPTH; i++) tag_q[i] <= tag_d[i];
    end
  end

  mac #(.AW(AW), .BW(BW), .PW(PW)) u_mac (
    .clk   (clk),
    .ain   (bus.a_rdata),
    .bin   (b_skew_q),
    .cin   (cin),
    .pout  (pout),
    .acout (acout_unused)
  );

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.rd_en  = issue;
  assign bus.a_addr = a_addr_q;
  assign bus.b_addr = b_addr_q;
  assign bus.result = result_q;
endmodule

// File: doc/mac_seq.md
Name: mac_seq

Overview:
- Dot-product sequencer that owns one `mac` instance (27x18 multiply, 48-bit post-add) and drives it from two single-port operand memories.
- On `start` it:
  - latches base addresses and length N;
  - streams N operand pairs into the MAC with the required A/B skew;
  - steers `cin` (zero or bias for the first product, `pout` feedback afterwards);
  - returns the accumulated result with a one-cycle `done` pulse.
- Sits between a control register block and the DSP datapath.

Parameters:
- AW, 27, A operand width (signed)
- BW, 18, B operand width (signed)
- PW, 48, accumulator/result width (signed)
- ADW, 10, operand memory address width
- LW, 11, length field width (N up to 2^LW-1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only in IDLE
- len  in  LW  element count N, unsigned, latched on accept
- a_base  in  ADW  A memory start address, latched on accept
- b_base  in  ADW  B memory start address, latched on accept
- busy  out  1  high from the accept cycle+1 through the DONE cycle
- done  out  1  single-cycle pulse, result valid
- result  out  PW  signed sum, held until the next accepted start
- rd_en  out  1  memory read strobe
- a_addr  out  ADW  A read address
- b_addr  out  ADW  B read address
- a_rdata  in  AW  A data, one cycle after rd_en
- b_rdata  in  BW  B data, one cycle after rd_en
- bias  in  PW  initial accumulator value (MAC_SEQ_BIAS_EN only)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, rd_en=0, result=0, addresses=0; tag pipeline cleared.
  - Reset mid-operation aborts immediately. Stale MAC internal registers are harmless because the tags are cleared.
- FSM:
  - IDLE -> ISSUE on start with len!=0.
  - IDLE -> DONE on start with len==0. Result=0 (bias if enabled); no reads.
  - ISSUE: N cycles, rd_en=1, a_addr=a_base+k, b_addr=b_base+k for k=0..N-1. Addresses wrap mod 2^ADW. -> DRAIN after k=N-1.
  - DRAIN: wait until the last tag leaves the pipeline -> DONE.
  - DONE: one cycle, done=1 -> IDLE.
  - start outside IDLE is ignored.
- Timing, with accept in cycle 0 and element k issued in cycle k+1:
  - a_rdata drives `ain` directly in cycle k+2.
  - b_rdata is registered once in a skew register, so `bin` = b_k in cycle k+3; this aligns ain_d2 and bin_d1 in cycle k+4.
  - mreg = a_k*b_k in cycle k+5; cin is selected in cycle k+5.
  - pout holds the partial sum in cycle k+6.
- cin select: 4-stage tag shift register {valid, first} launched with each issue.
  - cin = 0 (or bias) when the stage-4 tag has first=1;
  - otherwise cin = pout (back-to-back feedback, one accumulate per cycle).
- Completion:
  - The last partial sum is in pout in cycle N+5; it is captured into result at the end of that cycle.
  - done=1 and the new result are visible in cycle N+6. Start-to-done latency is N+6 cycles (N>=1).
  - Next start can be accepted in cycle N+7.
- Arithmetic: full signed product AW+BW bits. Accumulation wraps mod 2^PW with no saturation.
- `acout` is left unconnected.

Optional Feature:
- MAC_SEQ_BIAS_EN defined: the `bias` port exists and is used as cin for the first product. For len==0, result=bias.
- Undefined: no `bias` port; the first cin is 0.

Decomposition:
- Package mac_seq_pkg:
  - state enum (IDLE, ISSUE, DRAIN, DONE);
  - localparams RD_LAT=1, MAC_LAT=4 (ain to pout), TAG_DEPTH=4;
  - tag struct {valid, first}.
- One sub-module: the existing `mac`, instantiated unchanged. The cin mux, B skew register and tag pipeline live in mac_seq.

Test Plan:
- a=[1,2,3,4] @0, b=[5,6,7,8] @0, N=4 -> rd_en high cycles 1-4, done in cycle 10, result=70, busy falls after cycle 10.
- N=1, a=-3, b=7 -> done in cycle 7, result=-21; a second start issued in cycle 3 is ignored.
- Two back-to-back jobs (start in the cycle after done): {2,3}x{4,5} then {-1}x{-1} -> results 23 then 1; the first-product cin is zero each job (no carry-over).
- a_base=1022, ADW=10, N=4 -> a_addr sequence 1022, 1023, 0, 1; len=0 -> done in cycle 1, result=0, rd_en never high.
- Extremes: a=-2^26, b=-2^17, N=2 -> result=2^44. Accumulate overflow: 2^47-1 effective via repeated products wraps negative mod 2^48.
- rst_n pulsed low in cycle 3 of an N=8 job -> outputs return to reset values immediately; a fresh N=2 job afterwards gives the correct result. With MAC_SEQ_BIAS_EN, bias=100 and {1}x{1} -> result=101.
